// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: computes A - B - Bin with a single full-subtractor
//   cell, one bit per clock, LSB first, over WIDTH cycles. Operands are
//   captured from the switches on a rising edge of Go while idle; the result,
//   borrow-out and status are presented on the LEDs.
//
// Ports
//   CLOCK_50  in   1   system clock, all state changes on the rising edge
//   Resetn    in   1   asynchronous active-low reset
//   Go        in   1   start request, rising-edge detected
//   SW        in   9   SW[2*WIDTH]=Bin, SW[2*WIDTH-1:WIDTH]=A, SW[WIDTH-1:0]=B
//   LEDR      out  10  [WIDTH-1:0]=difference, [WIDTH]=borrow-out,
//                      [8]=valid, [9]=busy, all other bits 0
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       Go,
  input  logic [8:0] SW,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value of the last bit step; DONE follows the edge that sees it.
  localparam logic [2:0] CNT_LAST = 3'(WIDTH - 1);

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [WIDTH-1:0] res_q,      res_d;
  logic             br_q,       br_d;
  logic [2:0]       cnt_q,      cnt_d;
  logic             go_prev_q,  go_prev_d;
  logic [WIDTH-1:0] out_res_q,  out_res_d;
  logic             out_bout_q, out_bout_d;
  logic             valid_q,    valid_d;
  logic             busy_q,     busy_d;

  logic             start_s;
  logic             diff_bit_s;
  logic             br_next_s;
  logic [WIDTH:0]   res_shift_s;

  // Full-subtractor cell and start-edge detect.
  always_comb begin
    start_s     = Go & ~go_prev_q;
    diff_bit_s  = a_q[0] ^ b_q[0] ^ br_q;
    br_next_s   = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    // New difference bit enters at the MSB; result fills from the top.
    res_shift_s = {diff_bit_s, res_q} >> 1;
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    br_d       = br_q;
    cnt_d      = cnt_q;
    go_prev_d  = Go;
    out_res_d  = out_res_q;
    out_bout_d = out_bout_q;
    valid_d    = valid_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (start_s) begin
          a_d     = SW[2*WIDTH-1:WIDTH];
          b_d     = SW[WIDTH-1:0];
          br_d    = SW[2*WIDTH];
          res_d   = {WIDTH{1'b0}};
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next_s;
        res_d  = res_shift_s[WIDTH-1:0];
        cnt_d  = cnt_q + 3'd1;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        out_res_d  = res_q;
        out_bout_d = br_q;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; Go history resets high so a held Go cannot start a run.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      res_q      <= {WIDTH{1'b0}};
      br_q       <= 1'b0;
      cnt_q      <= 3'd0;
      go_prev_q  <= 1'b1;
      out_res_q  <= {WIDTH{1'b0}};
      out_bout_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      br_q       <= br_d;
      cnt_q      <= cnt_d;
      go_prev_q  <= go_prev_d;
      out_res_q  <= out_res_d;
      out_bout_q <= out_bout_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // LED map built purely from registered bits.
  always_comb begin
    LEDR            = {10{1'b0}};
    LEDR[WIDTH-1:0] = out_res_q;
    LEDR[WIDTH]     = out_bout_q;
    LEDR[8]         = valid_q;
    LEDR[9]         = busy_q;
  end

endmodule
